// File: rtl/cache_pkg.sv
// Shared constants and state type for the cache memory-side responder.
package cache_pkg;

    localparam int unsigned BLOCKSZ     = 512;
    localparam int unsigned WIDTH       = 64;
    localparam int unsigned ADDRESSSIZE = 64;
    localparam int unsigned BEATS       = BLOCKSZ / WIDTH;
    localparam int unsigned BEAT_W      = $clog2(BEATS);
    localparam int unsigned LEN_W       = 4;
    localparam int unsigned TIMEOUT     = 1024;
    localparam int unsigned TO_W        = $clog2(TIMEOUT) + 1;

    // Line-aligned (64 B) and beat-aligned (8 B) address masks.
    localparam logic [ADDRESSSIZE-1:0] LINE_MASK = 64'hFFFF_FFFF_FFFF_FFC0;
    localparam logic [ADDRESSSIZE-1:0] WORD_MASK = 64'hFFFF_FFFF_FFFF_FFF8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RD_ISSUE   = 3'd1,
        ST_RD_COLLECT = 3'd2,
        ST_WR_ISSUE   = 3'd3,
        ST_WR_WAIT    = 3'd4,
        ST_RESPOND    = 3'd5
    } resp_state_e;

endpackage

// File: rtl/line_assembler.sv
// Collects read-burst beats into one cache line.
// Ports: clr (zero line and beat counter), beat_valid/beat_data (incoming beat),
//        line (assembled line), beat_idx (slot of next beat), done (final beat this cycle).
module line_assembler
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               beat_valid,
    input  logic [WIDTH-1:0]   beat_data,
    output logic [BLOCKSZ-1:0] line,
    output logic [BEAT_W-1:0]  beat_idx,
    output logic               done
);

    logic [BLOCKSZ-1:0] line_q, line_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;

    // Beat counter wraps after the last slot, so every burst starts at slot 0.
    always_comb begin
        line_d = line_q;
        beat_d = beat_q;
        if (clr) begin
            line_d = '0;
            beat_d = '0;
        end else if (beat_valid) begin
            line_d[WIDTH*beat_q +: WIDTH] = beat_data;
            beat_d = beat_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
            beat_q <= '0;
        end else begin
            line_q <= line_d;
            beat_q <= beat_d;
        end
    end

    assign line     = line_q;
    assign beat_idx = beat_q;
    assign done     = beat_valid && (beat_q == BEAT_W'(BEATS - 1));

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder: turns cache line reads into 8-beat bus bursts and
// forwards writes as single-beat bus writes; pulses mem_data_valid on completion.
// Ports: cache side (mem_*), bus request (bus_req_*, bus_wdata), bus response
//        (bus_resp_*), status (busy, sticky protocol_err).
module cache_mem_responder
    import cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_req,
    input  logic [ADDRESSSIZE-1:0] mem_address,
    input  logic                   mem_wr_en,
    input  logic [WIDTH-1:0]       mem_data_out,
    output logic [BLOCKSZ-1:0]     mem_data_in,
    output logic                   mem_data_valid,
    output logic                   bus_req_valid,
    input  logic                   bus_req_ready,
    output logic [ADDRESSSIZE-1:0] bus_req_addr,
    output logic                   bus_req_wr,
    output logic [LEN_W-1:0]       bus_req_len,
    output logic [WIDTH-1:0]       bus_wdata,
    input  logic                   bus_resp_valid,
    input  logic [WIDTH-1:0]       bus_resp_data,
    input  logic                   bus_resp_last,
    output logic                   busy,
    output logic                   protocol_err
);

    resp_state_e            state_q, state_d;
    logic [TO_W-1:0]        cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [ADDRESSSIZE-1:0] addr_q, addr_d;
    logic                   wr_q, wr_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [WIDTH-1:0]       wdata_q, wdata_d;
    logic                   req_valid_q, data_valid_q, busy_q;

    logic                   clr;
    logic                   beat_valid;
    logic [BEAT_W-1:0]      beat_idx;
    logic                   done;
    logic                   waiting;
    logic                   progress;

    assign beat_valid = (state_q == ST_RD_COLLECT) && bus_resp_valid;

    line_assembler u_line (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .beat_valid (beat_valid),
        .beat_data  (bus_resp_data),
        .line       (mem_data_in),
        .beat_idx   (beat_idx),
        .done       (done)
    );

    // Next-state, request capture, error flagging and timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        len_d    = len_q;
        wdata_d  = wdata_q;
        clr      = 1'b0;
        waiting  = 1'b0;
        progress = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    wr_d    = mem_wr_en;
                    wdata_d = mem_data_out;
                    if (mem_wr_en) begin
                        addr_d  = mem_address & WORD_MASK;
                        len_d   = '0;
                        state_d = ST_WR_ISSUE;
                    end else begin
                        addr_d  = mem_address & LINE_MASK;
                        len_d   = LEN_W'(BEATS - 1);
                        state_d = ST_RD_ISSUE;
                    end
                end
                if (bus_resp_valid) err_d = 1'b1;
            end
            ST_RD_ISSUE: begin
                waiting  = 1'b1;
                progress = bus_req_ready;
                if (bus_req_ready) state_d = ST_RD_COLLECT;
            end
            ST_RD_COLLECT: begin
                waiting  = 1'b1;
                progress = bus_resp_valid;
                if (beat_valid) begin
                    // Early last is flagged but the burst still runs to 8 beats.
                    if (bus_resp_last && (beat_idx != BEAT_W'(BEATS - 1))) err_d = 1'b1;
                    if (done) begin
                        if (!bus_resp_last) err_d = 1'b1;
                        state_d = ST_RESPOND;
                    end
                end
            end
            ST_WR_ISSUE: begin
                waiting  = 1'b1;
                progress = bus_req_ready;
                if (bus_req_ready) state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                waiting  = 1'b1;
                progress = bus_resp_valid;
                if (bus_resp_valid) state_d = ST_RESPOND;
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
                if (bus_resp_valid) err_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Requests are never queued: anything outside IDLE is dropped and flagged.
        if (mem_req && (state_q != ST_IDLE)) err_d = 1'b1;

        // Stall counter restarts on every handshake/beat; expiry aborts to RESPOND.
        if (waiting && !progress) begin
            if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                err_d   = 1'b1;
                clr     = 1'b1;
                state_d = ST_RESPOND;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + TO_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Datapath and registered outputs, decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            len_q        <= '0;
            wdata_q      <= '0;
            req_valid_q  <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            len_q        <= len_d;
            wdata_q      <= wdata_d;
            req_valid_q  <= (state_d == ST_RD_ISSUE) || (state_d == ST_WR_ISSUE);
            data_valid_q <= (state_d == ST_RESPOND);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign mem_data_valid = data_valid_q;
    assign bus_req_valid  = req_valid_q;
    assign bus_req_addr   = addr_q;
    assign bus_req_wr     = wr_q;
    assign bus_req_len    = len_q;
    assign bus_wdata      = wdata_q;
    assign busy           = busy_q;
    assign protocol_err   = err_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed + randomized bench for cache_mem_responder with a transaction-level model.
module tb_cache_mem_responder;

    localparam int TO_CYC = 1024;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_req;
    logic [63:0]  mem_address;
    logic         mem_wr_en;
    logic [63:0]  mem_data_out;
    logic [511:0] mem_data_in;
    logic         mem_data_valid;
    logic         bus_req_valid;
    logic         bus_req_ready;
    logic [63:0]  bus_req_addr;
    logic         bus_req_wr;
    logic [3:0]   bus_req_len;
    logic [63:0]  bus_wdata;
    logic         bus_resp_valid;
    logic [63:0]  bus_resp_data;
    logic         bus_resp_last;
    logic         busy;
    logic         protocol_err;

    cache_mem_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_address    (mem_address),
        .mem_wr_en      (mem_wr_en),
        .mem_data_out   (mem_data_out),
        .mem_data_in    (mem_data_in),
        .mem_data_valid (mem_data_valid),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_req_addr   (bus_req_addr),
        .bus_req_wr     (bus_req_wr),
        .bus_req_len    (bus_req_len),
        .bus_wdata      (bus_wdata),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_data  (bus_resp_data),
        .bus_resp_last  (bus_resp_last),
        .busy           (busy),
        .protocol_err   (protocol_err)
    );

    always #5 clk = ~clk;

    int           tests = 0;
    int           fails = 0;
    logic [511:0] m_line;     // line the cache should currently see
    logic         m_err;      // expected sticky error flag
    logic [63:0]  bd [8];     // beat data for the next read

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mdv"},  mem_data_valid, 0);
        check({tag, "_mdi"},  mem_data_in, 0);
        check({tag, "_brv"},  bus_req_valid, 0);
        check({tag, "_addr"}, bus_req_addr, 0);
        check({tag, "_wr"},   bus_req_wr, 0);
        check({tag, "_len"},  bus_req_len, 0);
        check({tag, "_wd"},   bus_wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"},  protocol_err, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n  = 1'b1;
        m_line = '0;
        m_err  = 1'b0;
        tick();
    endtask

    // Line read: ready after ready_wait stalls, optional random beat gaps,
    // optional early last / missing last / stray mem_req before beat mreq_at.
    task automatic do_read(input logic [63:0] addr, input int ready_wait, input bit gaps,
                           input int early_last, input bit drop_last, input int mreq_at);
        logic [63:0]  ea;
        logic [511:0] eline;
        int           ng;
        ea = addr - (addr % 64);
        for (int b = 0; b < 8; b++) eline[64*b +: 64] = bd[b];
        mem_req = 1'b1; mem_address = addr; mem_wr_en = 1'b0; mem_data_out = {$urandom, $urandom};
        tick();
        mem_req = 1'b0;
        check("rd_req_valid", bus_req_valid, 1);
        check("rd_req_addr",  bus_req_addr, ea);
        check("rd_req_len",   bus_req_len, 7);
        check("rd_req_wr",    bus_req_wr, 0);
        check("rd_busy",      busy, 1);
        check("rd_line_held", mem_data_in, m_line);
        for (int i = 0; i < ready_wait; i++) begin
            tick();
            check("rd_wait_valid", bus_req_valid, 1);
            check("rd_wait_addr",  bus_req_addr, ea);
            check("rd_wait_len",   bus_req_len, 7);
        end
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        check("rd_valid_drop", bus_req_valid, 0);
        for (int b = 0; b < 8; b++) begin
            if (b == mreq_at) begin
                mem_req = 1'b1; mem_address = ~addr; mem_wr_en = 1'b1;
                tick();
                mem_req = 1'b0; mem_wr_en = 1'b0;
            end
            if (gaps) begin
                ng = $urandom_range(0, 2);
                for (int g = 0; g < ng; g++) tick();
            end
            bus_resp_valid = 1'b1;
            bus_resp_data  = bd[b];
            bus_resp_last  = (b == early_last) || (b == 7 && !drop_last);
            tick();
            bus_resp_valid = 1'b0;
            bus_resp_last  = 1'b0;
            if (b < 7) check("rd_no_early_mdv", mem_data_valid, 0);
        end
        if (early_last >= 0 || drop_last || mreq_at >= 0) m_err = 1'b1;
        m_line = eline;
        check("rd_mdv",      mem_data_valid, 1);
        check("rd_line",     mem_data_in, m_line);
        check("rd_err",      protocol_err, m_err);
        check("rd_addr_kept", bus_req_addr, ea);
        tick();
        check("rd_mdv_once", mem_data_valid, 0);
        check("rd_idle",     busy, 0);
        check("rd_line_hold", mem_data_in, m_line);
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [63:0] data, input int ack_wait);
        logic [63:0] ea;
        ea = addr - (addr % 8);
        mem_req = 1'b1; mem_address = addr; mem_wr_en = 1'b1; mem_data_out = data;
        tick();
        mem_req = 1'b0; mem_wr_en = 1'b0;
        check("wr_req_valid", bus_req_valid, 1);
        check("wr_req_addr",  bus_req_addr, ea);
        check("wr_req_wr",    bus_req_wr, 1);
        check("wr_req_len",   bus_req_len, 0);
        check("wr_wdata",     bus_wdata, data);
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        check("wr_valid_drop", bus_req_valid, 0);
        for (int i = 0; i < ack_wait; i++) begin
            check("wr_wait_mdv", mem_data_valid, 0);
            tick();
        end
        bus_resp_valid = 1'b1;
        tick();
        bus_resp_valid = 1'b0;
        check("wr_mdv",  mem_data_valid, 1);
        check("wr_line", mem_data_in, m_line);
        check("wr_err",  protocol_err, m_err);
        tick();
        check("wr_mdv_once", mem_data_valid, 0);
        check("wr_idle",     busy, 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; mem_req = 1'b0; mem_address = '0; mem_wr_en = 1'b0; mem_data_out = '0;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_data = '0; bus_resp_last = 1'b0;
        m_line = '0; m_err = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Zero-wait read with beats 0..7
        for (int b = 0; b < 8; b++) bd[b] = 64'(b);
        do_read(64'h1234_5678_9ABC, 0, 1'b0, -1, 1'b0, -1);
        check("t1_low_beat",  mem_data_in[63:0], 64'h0);
        check("t1_high_beat", mem_data_in[511:448], 64'h7);

        // Write with ack after 5 cycles
        do_write(64'h1000_0007, 64'hDEAD_BEEF, 5);

        // Stalled request and random beat gaps
        for (int b = 0; b < 8; b++) bd[b] = {$urandom, $urandom};
        do_read({$urandom, $urandom}, 20, 1'b1, -1, 1'b0, -1);

        // Randomized mix
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < 8; b++) bd[b] = {$urandom, $urandom};
                do_read({$urandom, $urandom}, $urandom_range(0, 4), 1'b1, -1, 1'b0, -1);
            end else begin
                do_write({$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 6));
            end
        end

        // Async reset during beat 3, then a clean read
        for (int b = 0; b < 8; b++) bd[b] = {$urandom, $urandom};
        mem_req = 1'b1; mem_address = 64'h40; mem_wr_en = 1'b0;
        tick();
        mem_req = 1'b0;
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus_resp_valid = 1'b1; bus_resp_data = bd[b];
            tick();
        end
        bus_resp_data = bd[3];
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        bus_resp_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m_line = '0; m_err = 1'b0;
        tick();
        for (int b = 0; b < 8; b++) bd[b] = {$urandom, $urandom};
        do_read(64'h0000_0000_0000_1FFF, 0, 1'b0, -1, 1'b0, -1);
        check("post_rst_err", protocol_err, 0);

        // Stray response while idle
        bus_resp_valid = 1'b1;
        tick();
        bus_resp_valid = 1'b0;
        m_err = 1'b1;
        check("idle_resp_err", protocol_err, m_err);
        check("idle_resp_busy", busy, 0);
        do_reset();

        // Timeout with the bus silent
        mem_req = 1'b1; mem_address = 64'hABCD_0000; mem_wr_en = 1'b0;
        tick();
        mem_req = 1'b0;
        n = 0;
        while (!mem_data_valid && n < TO_CYC + 50) begin
            tick();
            n++;
            if (n == TO_CYC / 2) check("to_valid_held", bus_req_valid, 1);
        end
        check("to_seen",   mem_data_valid, 1);
        check("to_window", (n >= TO_CYC - 1) && (n <= TO_CYC + 2), 1);
        check("to_err",    protocol_err, 1);
        check("to_line",   mem_data_in, 0);
        check("to_brv",    bus_req_valid, 0);
        tick();
        check("to_mdv_once", mem_data_valid, 0);
        check("to_idle",     busy, 0);
        do_reset();

        // Stray mem_req mid-burst plus early last at beat 5
        for (int b = 0; b < 8; b++) bd[b] = {$urandom, $urandom};
        do_read(64'h8765_4321_0000_0040, 1, 1'b0, 5, 1'b0, 3);
        do_reset();

        // Final beat missing its last marker
        for (int b = 0; b < 8; b++) bd[b] = {$urandom, $urandom};
        do_read(64'h0F0F_F0F0_1234_5678, 0, 1'b1, -1, 1'b1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
